// File: rtl/branch_exec_unit.sv
// Branch execution unit: resolves conditional branches, JAL and JALR
// against the front-end prediction. One result register with a
// ready/valid handshake on both sides, plus saturating statistics counters.
module branch_exec_unit #(
  parameter int XLEN   = 32,
  parameter int ROB_W  = 5,
  parameter int PREG_W = 7,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_func3,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [PREG_W-1:0] in_pd,
  input  logic [ROB_W-1:0]  in_rob,
  input  logic              in_pred_taken,
  input  logic [XLEN-1:0]   in_pred_target,
  input  logic [XLEN-1:0]   ps1_data,
  input  logic [XLEN-1:0]   ps2_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ROB_W-1:0]  out_rob,
  output logic [PREG_W-1:0] out_pd,
  output logic              out_wr_en,
  output logic [XLEN-1:0]   out_data,
  output logic              out_taken,
  output logic              out_mispredict,
  output logic [XLEN-1:0]   out_redirect_pc,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  cnt_resolved,
  output logic [CNT_W-1:0]  cnt_mispredict
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [ROB_W-1:0]  rob;
    logic [PREG_W-1:0] pd;
    logic              wr_en;
    logic [XLEN-1:0]   data;
    logic              taken;
    logic              mispredict;
    logic [XLEN-1:0]   redirect_pc;
    logic              illegal;
  } res_t;

  res_t res_d, res_q;

  logic            is_br, is_jal, is_jalr, is_link;
  logic            br_taken, br_ok, taken, illegal;
  logic [XLEN-1:0] seq_pc, pc_target, jalr_sum, target;
  logic            accept, drain;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign drain    = out_valid && out_ready;

  assign is_br   = (in_opcode == OP_BRANCH);
  assign is_jal  = (in_opcode == OP_JAL);
  assign is_jalr = (in_opcode == OP_JALR) && (in_func3 == 3'b000);
  assign is_link = is_jal || is_jalr;

  // Branch condition by func3; 010/011 are holes in the encoding.
  always_comb begin
    br_taken = 1'b0;
    br_ok    = 1'b1;
    case (in_func3)
      3'b000:  br_taken = (ps1_data == ps2_data);
      3'b001:  br_taken = (ps1_data != ps2_data);
      3'b100:  br_taken = ($signed(ps1_data) <  $signed(ps2_data));
      3'b101:  br_taken = ($signed(ps1_data) >= $signed(ps2_data));
      3'b110:  br_taken = (ps1_data <  ps2_data);
      3'b111:  br_taken = (ps1_data >= ps2_data);
      default: br_ok    = 1'b0;
    endcase
  end

  // All sums wrap modulo 2^XLEN; JALR clears bit 0 of its target.
  assign seq_pc    = in_pc + XLEN'(4);
  assign pc_target = in_pc + in_imm;
  assign jalr_sum  = ps1_data + in_imm;
  assign target    = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : pc_target;
  assign taken     = is_link || (is_br && br_taken);
  assign illegal   = !(is_link || (is_br && br_ok));

  // Assemble the result that an accepted op loads into the output register.
  always_comb begin
    res_d             = '0;
    res_d.rob         = in_rob;
    res_d.pd          = in_pd;
    res_d.wr_en       = is_link && (in_pd != '0);
    res_d.data        = (is_link && (in_pd != '0)) ? seq_pc : '0;
    res_d.taken       = taken;
    res_d.mispredict  = (taken != in_pred_taken) ||
                        (taken && (in_pred_target != target));
    res_d.redirect_pc = taken ? target : seq_pc;
    res_d.illegal     = illegal;
  end

  // Output register: flush beats accept, accept beats drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      res_q     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      res_q     <= res_d;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

  // Statistics on completed handshakes; a flushed result is never counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_resolved   <= '0;
      cnt_mispredict <= '0;
    end else if (drain && !flush) begin
      if (!res_q.illegal && (cnt_resolved != '1))
        cnt_resolved <= cnt_resolved + CNT_ONE;
      if (res_q.mispredict && (cnt_mispredict != '1))
        cnt_mispredict <= cnt_mispredict + CNT_ONE;
    end
  end

  assign out_rob         = res_q.rob;
  assign out_pd          = res_q.pd;
  assign out_wr_en       = res_q.wr_en;
  assign out_data        = res_q.data;
  assign out_taken       = res_q.taken;
  assign out_mispredict  = res_q.mispredict;
  assign out_redirect_pc = res_q.redirect_pc;
  assign out_illegal     = res_q.illegal;

endmodule

// File: tb/tb_branch_exec_unit.sv
// Directed bench for branch_exec_unit: a vector table for resolution logic
// plus hand sequences for stall, flush, reset and counter saturation.
module tb_branch_exec_unit;
  localparam int XLEN = 32, ROB_W = 5, PREG_W = 7, CNT_W = 2;

  logic              clk = 1'b0, reset = 1'b1;
  logic              in_valid = 1'b0, in_ready;
  logic [6:0]        in_opcode = '0;
  logic [2:0]        in_func3 = '0;
  logic [XLEN-1:0]   in_pc = '0, in_imm = '0, in_pred_target = '0;
  logic [XLEN-1:0]   ps1_data = '0, ps2_data = '0;
  logic [PREG_W-1:0] in_pd = '0;
  logic [ROB_W-1:0]  in_rob = '0;
  logic              in_pred_taken = 1'b0, flush = 1'b0;
  logic              out_valid, out_ready = 1'b1;
  logic [ROB_W-1:0]  out_rob;
  logic [PREG_W-1:0] out_pd;
  logic              out_wr_en, out_taken, out_mispredict, out_illegal;
  logic [XLEN-1:0]   out_data, out_redirect_pc;
  logic [CNT_W-1:0]  cnt_resolved, cnt_mispredict;

  branch_exec_unit #(.XLEN(XLEN), .ROB_W(ROB_W), .PREG_W(PREG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_func3(in_func3), .in_pc(in_pc), .in_imm(in_imm),
    .in_pd(in_pd), .in_rob(in_rob), .in_pred_taken(in_pred_taken),
    .in_pred_target(in_pred_target), .ps1_data(ps1_data), .ps2_data(ps2_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_rob(out_rob),
    .out_pd(out_pd), .out_wr_en(out_wr_en), .out_data(out_data), .out_taken(out_taken),
    .out_mispredict(out_mispredict), .out_redirect_pc(out_redirect_pc),
    .out_illegal(out_illegal), .cnt_resolved(cnt_resolved), .cnt_mispredict(cnt_mispredict)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, RTYPE = 7'b0110011;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] pc, imm;
    logic [6:0]  pd;
    logic        pt;
    logic [31:0] ptgt, ps1, ps2;
    logic        e_taken, e_mis;
    logic [31:0] e_redir;
    logic        e_wr;
    logic [31:0] e_data;
    logic        e_ill;
  } vec_t;

  vec_t vecs[14];
  int n_cmp = 0, n_err = 0;

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3,
                              input logic [31:0] pc, imm, input logic [6:0] pd,
                              input logic pt, input logic [31:0] ptgt, ps1, ps2,
                              input logic e_taken, e_mis, input logic [31:0] e_redir,
                              input logic e_wr, input logic [31:0] e_data, input logic e_ill);
    vec_t v;
    v.op = op; v.f3 = f3; v.pc = pc; v.imm = imm; v.pd = pd; v.pt = pt;
    v.ptgt = ptgt; v.ps1 = ps1; v.ps2 = ps2; v.e_taken = e_taken; v.e_mis = e_mis;
    v.e_redir = e_redir; v.e_wr = e_wr; v.e_data = e_data; v.e_ill = e_ill;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v, input logic [4:0] rob);
    in_opcode = v.op; in_func3 = v.f3; in_pc = v.pc; in_imm = v.imm; in_pd = v.pd;
    in_rob = rob; in_pred_taken = v.pt; in_pred_target = v.ptgt;
    ps1_data = v.ps1; ps2_data = v.ps2; in_valid = 1'b1;
  endtask

  task automatic check_out(input string tag, input vec_t v, input logic [4:0] rob);
    chk({tag, ".valid"}, out_valid, 1);
    chk({tag, ".rob"}, out_rob, rob);
    chk({tag, ".pd"}, out_pd, v.pd);
    chk({tag, ".taken"}, out_taken, v.e_taken);
    chk({tag, ".mispredict"}, out_mispredict, v.e_mis);
    chk({tag, ".redirect"}, out_redirect_pc, v.e_redir);
    chk({tag, ".wr_en"}, out_wr_en, v.e_wr);
    chk({tag, ".data"}, out_data, v.e_data);
    chk({tag, ".illegal"}, out_illegal, v.e_ill);
  endtask

  task automatic do_reset;
    in_valid = 1'b0; flush = 1'b0; reset = 1'b1;
    step;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //            op    f3      pc            imm           pd pt ptgt          ps1           ps2          tk mis redir         wr data        ill
    vecs[0]  = mk(BR,   3'b001, 32'h100,      32'h20,       1, 0, 32'h0,      32'h5,        32'h5,        0, 0, 32'h104,      0, 32'h0,      0);
    vecs[1]  = mk(BR,   3'b100, 32'h200,      32'h40,       2, 0, 32'h0,      32'hFFFFFFFF, 32'h1,        1, 1, 32'h240,      0, 32'h0,      0);
    vecs[2]  = mk(BR,   3'b110, 32'h200,      32'h40,       2, 0, 32'h0,      32'hFFFFFFFF, 32'h1,        0, 0, 32'h204,      0, 32'h0,      0);
    vecs[3]  = mk(JALR, 3'b000, 32'h300,      32'h10,       7, 1, 32'h1010,   32'h1001,     32'h0,        1, 0, 32'h1010,     1, 32'h304,    0);
    vecs[4]  = mk(BR,   3'b000, 32'h400,      32'hFFFFFFF8, 4, 1, 32'h3F8,    32'h3,        32'h3,        1, 0, 32'h3F8,      0, 32'h0,      0);
    vecs[5]  = mk(BR,   3'b101, 32'h500,      32'h10,       4, 1, 32'h500,    32'h1,        32'hFFFFFFFF, 1, 1, 32'h510,      0, 32'h0,      0);
    vecs[6]  = mk(BR,   3'b111, 32'h500,      32'h10,       4, 0, 32'h0,      32'h1,        32'hFFFFFFFF, 0, 0, 32'h504,      0, 32'h0,      0);
    vecs[7]  = mk(JAL,  3'b000, 32'hFFFFFFF0, 32'h20,       0, 0, 32'h0,      32'h0,        32'h0,        1, 1, 32'h10,       0, 32'h0,      0);
    vecs[8]  = mk(JAL,  3'b000, 32'h600,      32'h100,      3, 1, 32'h700,    32'h0,        32'h0,        1, 0, 32'h700,      1, 32'h604,    0);
    vecs[9]  = mk(BR,   3'b010, 32'h700,      32'h8,        1, 1, 32'h708,    32'h1,        32'h1,        0, 1, 32'h704,      0, 32'h0,      1);
    vecs[10] = mk(JALR, 3'b001, 32'h800,      32'h8,        5, 0, 32'h0,      32'h100,      32'h0,        0, 0, 32'h804,      0, 32'h0,      1);
    vecs[11] = mk(RTYPE,3'b000, 32'h900,      32'h0,        6, 0, 32'h0,      32'h1,        32'h2,        0, 0, 32'h904,      0, 32'h0,      1);
    vecs[12] = mk(BR,   3'b001, 32'hFFFFFFFC, 32'h0,        1, 0, 32'h0,      32'h1,        32'h2,        1, 1, 32'hFFFFFFFC, 0, 32'h0,      0);
    vecs[13] = mk(BR,   3'b000, 32'hFFFFFFFC, 32'h8,        1, 0, 32'h0,      32'h1,        32'h2,        0, 0, 32'h0,        0, 32'h0,      0);

    // Reset state before any clock edge, then right after release.
    #1;
    chk("rst.valid", out_valid, 0);
    chk("rst.in_ready", in_ready, 1);
    chk("rst.redirect", out_redirect_pc, 0);
    chk("rst.cnt_res", cnt_resolved, 0);
    chk("rst.cnt_mis", cnt_mispredict, 0);
    step; step;
    reset = 1'b0;
    chk("post_rst.in_ready", in_ready, 1);

    // Vector table, back-to-back with the consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i], 5'(i));
      step;
      check_out($sformatf("vec%0d", i), vecs[i], 5'(i));
    end
    in_valid = 1'b0;
    step;
    chk("vec.drained", out_valid, 0);

    // Single BNE handshake bumps cnt_resolved.
    do_reset;
    drive(vecs[0], 5'd3);
    step;
    in_valid = 1'b0;
    chk("bne.valid", out_valid, 1);
    chk("bne.cnt_before", cnt_resolved, 0);
    step;
    chk("bne.cnt_res", cnt_resolved, 1);
    chk("bne.cnt_mis", cnt_mispredict, 0);
    chk("bne.valid_after", out_valid, 0);

    // Back-pressure: hold for 3 cycles, then drain and accept together.
    do_reset;
    out_ready = 1'b0;
    drive(vecs[1], 5'd9);
    step;
    drive(vecs[2], 5'd10);
    for (int k = 0; k < 3; k++) begin
      chk("stall.in_ready", in_ready, 0);
      check_out("stall", vecs[1], 5'd9);
      step;
    end
    check_out("stall.end", vecs[1], 5'd9);
    out_ready = 1'b1;
    #1;
    chk("stall.in_ready_rel", in_ready, 1);
    step;
    in_valid = 1'b0;
    check_out("b2b", vecs[2], 5'd10);
    chk("b2b.cnt_res", cnt_resolved, 1);
    chk("b2b.cnt_mis", cnt_mispredict, 1);
    step;
    chk("b2b.cnt_res2", cnt_resolved, 2);
    chk("b2b.cnt_mis2", cnt_mispredict, 1);
    chk("b2b.valid_after", out_valid, 0);

    // Flush kills the held result and drops the same-cycle input.
    do_reset;
    out_ready = 1'b0;
    drive(vecs[1], 5'd1);
    step;
    chk("flush.pre_valid", out_valid, 1);
    drive(vecs[3], 5'd2);
    flush = 1'b1;
    step;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush.valid", out_valid, 0);
    chk("flush.cnt_res", cnt_resolved, 0);
    chk("flush.cnt_mis", cnt_mispredict, 0);
    out_ready = 1'b1;
    step;
    chk("flush.still_empty", out_valid, 0);
    chk("flush.cnt_res2", cnt_resolved, 0);

    // Reset mid-hold clears everything without a clock edge.
    out_ready = 1'b0;
    drive(vecs[3], 5'd7);
    step;
    in_valid = 1'b0;
    chk("rmid.pre_valid", out_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("rmid.valid", out_valid, 0);
    chk("rmid.taken", out_taken, 0);
    chk("rmid.redirect", out_redirect_pc, 0);
    chk("rmid.data", out_data, 0);
    chk("rmid.wr_en", out_wr_en, 0);
    chk("rmid.rob", out_rob, 0);
    chk("rmid.pd", out_pd, 0);
    chk("rmid.in_ready", in_ready, 1);
    step;
    reset = 1'b0;
    out_ready = 1'b1;

    // Illegal op counts a mispredict but not a resolution.
    do_reset;
    drive(vecs[9], 5'd4);
    step;
    in_valid = 1'b0;
    step;
    chk("ill.cnt_res", cnt_resolved, 0);
    chk("ill.cnt_mis", cnt_mispredict, 1);

    // Five mispredicting handshakes saturate 2-bit counters at 3.
    do_reset;
    drive(vecs[1], 5'd5);
    for (int k = 0; k < 5; k++) step;
    in_valid = 1'b0;
    step;
    chk("sat.cnt_mis", cnt_mispredict, 3);
    chk("sat.cnt_res", cnt_resolved, 3);
    chk("sat.valid", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
